// File: rtl/morra_if.sv
// Game-side bundle between morra_driver and the MorraCinese FSM,
// plus the match control/status lines.
interface morra_if #(
    parameter int CNT_W = 5
);
    logic             START;
    logic [3:0]       NMAN;
    logic [1:0]       MANCHE_IN;
    logic [1:0]       PARTITA_IN;
    logic [1:0]       PRIMO;
    logic [1:0]       SECONDO;
    logic             INIZIA;
    logic             BUSY;
    logic             DONE;
    logic             TIMEOUT;
    logic [1:0]       RESULT;
    logic [CNT_W-1:0] WINS1;
    logic [CNT_W-1:0] WINS2;
    logic [CNT_W-1:0] DRAWS;
    logic [CNT_W-1:0] INVALIDS;

    modport master (
        input  START, NMAN, MANCHE_IN, PARTITA_IN,
        output PRIMO, SECONDO, INIZIA, BUSY, DONE,
        output TIMEOUT, RESULT,
        output WINS1, WINS2, DRAWS, INVALIDS
    );

    modport slave (
        output START, NMAN, MANCHE_IN, PARTITA_IN,
        input  PRIMO, SECONDO, INIZIA, BUSY, DONE,
        input  TIMEOUT, RESULT,
        input  WINS1, WINS2, DRAWS, INVALIDS
    );
endinterface

// File: rtl/morra_driver.sv
// Self-play match sequencer for the MorraCinese game FSM.
// Optional: MORRA_INVALID_INJECT_EN forces PRIMO=00 every 4th PLAY cycle.
module morra_driver #(
    parameter logic [7:0] SEED1      = 8'hA5,
    parameter logic [7:0] SEED2      = 8'h3C,
    parameter int         MAX_CYCLES = 32,
    parameter int         CNT_W      = 5
) (
    input logic      clk,
    input logic      rst,
    morra_if.master  m
);
    localparam int CYC_W = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, INIT, PLAY} state_t;

    state_t st, st_nx;

    logic [7:0]       l1, l1_nx, l2, l2_nx;
    logic [CYC_W-1:0] cyc, cyc_nx;
    logic [1:0]       primo, primo_nx, secondo, secondo_nx;
    logic [1:0]       result, result_nx;
    logic             inizia, inizia_nx, busy, busy_nx;
    logic             done, done_nx, tmo, tmo_nx;
    logic [CNT_W-1:0] w1, w1_nx, w2, w2_nx;
    logic [CNT_W-1:0] dr, dr_nx, inv, inv_nx;

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [1:0] mv(input logic [1:0] r);
        return (r == 2'b00) ? 2'b01 : r;
    endfunction

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx      = st;
        l1_nx      = l1;
        l2_nx      = l2;
        cyc_nx     = cyc;
        primo_nx   = primo;
        secondo_nx = secondo;
        result_nx  = result;
        inizia_nx  = 1'b0;
        busy_nx    = busy;
        done_nx    = 1'b0;
        tmo_nx     = tmo;
        w1_nx      = w1;
        w2_nx      = w2;
        dr_nx      = dr;
        inv_nx     = inv;
        unique case (st)
            IDLE: begin
                if (m.START) begin
                    st_nx      = INIT;
                    inizia_nx  = 1'b1;
                    busy_nx    = 1'b1;
                    primo_nx   = m.NMAN[3:2];
                    secondo_nx = m.NMAN[1:0];
                    tmo_nx     = 1'b0;
                    cyc_nx     = '0;
                    w1_nx      = '0;
                    w2_nx      = '0;
                    dr_nx      = '0;
                    inv_nx     = '0;
                end
            end
            INIT: begin
                st_nx      = PLAY;
                l1_nx      = step(l1);
                l2_nx      = step(l2);
                primo_nx   = mv(l1_nx[1:0]);
                secondo_nx = mv(l2_nx[1:0]);
            end
            PLAY: begin
                cyc_nx = cyc + CYC_W'(1);
                // first PLAY edge carries the verdict of the INIT config
                if (cyc != '0) begin
                    case (m.MANCHE_IN)
                        2'b01:   w1_nx  = inc(w1);
                        2'b10:   w2_nx  = inc(w2);
                        2'b11:   dr_nx  = inc(dr);
                        default: inv_nx = inc(inv);
                    endcase
                end
                if (cyc != '0 && m.PARTITA_IN != 2'b00) begin
                    st_nx      = IDLE;
                    result_nx  = m.PARTITA_IN;
                    done_nx    = 1'b1;
                    busy_nx    = 1'b0;
                    primo_nx   = 2'b00;
                    secondo_nx = 2'b00;
                end else if (cyc_nx == CYC_W'(MAX_CYCLES)) begin
                    st_nx      = IDLE;
                    tmo_nx     = 1'b1;
                    result_nx  = 2'b00;
                    done_nx    = 1'b1;
                    busy_nx    = 1'b0;
                    primo_nx   = 2'b00;
                    secondo_nx = 2'b00;
                end else begin
                    l1_nx      = step(l1);
                    l2_nx      = step(l2);
                    primo_nx   = mv(l1_nx[1:0]);
                    secondo_nx = mv(l2_nx[1:0]);
`ifdef MORRA_INVALID_INJECT_EN
                    if (cyc_nx[1:0] == 2'b11) primo_nx = 2'b00;
`endif
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l1      <= SEED1;
            l2      <= SEED2;
            cyc     <= '0;
            primo   <= 2'b00;
            secondo <= 2'b00;
            result  <= 2'b00;
            inizia  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tmo     <= 1'b0;
            w1      <= '0;
            w2      <= '0;
            dr      <= '0;
            inv     <= '0;
        end else begin
            l1      <= l1_nx;
            l2      <= l2_nx;
            cyc     <= cyc_nx;
            primo   <= primo_nx;
            secondo <= secondo_nx;
            result  <= result_nx;
            inizia  <= inizia_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            tmo     <= tmo_nx;
            w1      <= w1_nx;
            w2      <= w2_nx;
            dr      <= dr_nx;
            inv     <= inv_nx;
        end
    end

    assign m.PRIMO    = primo;
    assign m.SECONDO  = secondo;
    assign m.INIZIA   = inizia;
    assign m.BUSY     = busy;
    assign m.DONE     = done;
    assign m.TIMEOUT  = tmo;
    assign m.RESULT   = result;
    assign m.WINS1    = w1;
    assign m.WINS2    = w2;
    assign m.DRAWS    = dr;
    assign m.INVALIDS = inv;
endmodule

// File: tb/tb_morra_driver.sv
// Directed bench for morra_driver with a registered game model
// and a tally scoreboard.
module tb_morra_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    morra_if #(.CNT_W(5)) mif ();
    morra_if #(.CNT_W(5)) sif ();

    morra_driver dut (.clk(clk), .rst(rst), .m(mif.master));
    morra_driver #(.MAX_CYCLES(48)) sat (.clk(clk), .rst(rst), .m(sif.master));

    typedef struct packed {
        logic [1:0] man;
        logic [1:0] par;
    } ent_t;

    ent_t sb[$];
    int checks = 0;
    int fails = 0;
    int m_w1, m_w2, m_dr, m_inv;
    int nplay, end_at, spike_at, done_cnt;
    logic [1:0] end_val, pend, force_val;
    bit force_en, prev_play;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rock 01, paper 10, scissors 11; 00 move -> invalid round
    function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        if (a == b) return 2'b11;
        if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
            (a == 2'b11 && b == 2'b10)) return 2'b01;
        return 2'b10;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 31) ? 31 : v + 1;
    endfunction

    function automatic int dut_sum();
        return int'(mif.WINS1) + int'(mif.WINS2) + int'(mif.DRAWS) + int'(mif.INVALIDS);
    endfunction

    task automatic model_clr();
        m_w1 = 0; m_w2 = 0; m_dr = 0; m_inv = 0;
        sb.delete();
        nplay = 0;
        prev_play = 1'b0;
    endtask

    task automatic tick();
        ent_t e;
        bit cur, el;
        int ntal;
        @(negedge clk);
        if (mif.DONE) done_cnt++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.man)
                2'b01:   m_w1 = sat_inc(m_w1);
                2'b10:   m_w2 = sat_inc(m_w2);
                2'b11:   m_dr = sat_inc(m_dr);
                default: m_inv = sat_inc(m_inv);
            endcase
            if (e.par != 2'b00) begin
                chk("done_on_verdict", 32'(mif.DONE), 32'd1);
                chk("verdict_result", 32'(mif.RESULT), 32'(e.par));
            end
        end
        chk("tallies",
            {12'd0, mif.WINS1, mif.WINS2, mif.DRAWS, mif.INVALIDS},
            {12'd0, 5'(m_w1), 5'(m_w2), 5'(m_dr), 5'(m_inv)});
        cur = mif.BUSY && !mif.INIZIA;
        if (cur) begin
            nplay++;
`ifdef MORRA_INVALID_INJECT_EN
            if (nplay % 4 == 0) chk("inject_primo", 32'(mif.PRIMO), 32'd0);
            else chk("primo_valid", 32'(mif.PRIMO != 2'b00), 32'd1);
`else
            chk("primo_valid", 32'(mif.PRIMO != 2'b00), 32'd1);
`endif
            chk("secondo_valid", 32'(mif.SECONDO != 2'b00), 32'd1);
        end
        if (nplay > 0 && mif.BUSY) chk("no_reinit", 32'(mif.INIZIA), 32'd0);
        el = cur && prev_play;
        ntal = m_w1 + m_w2 + m_dr + m_inv;
        mif.MANCHE_IN = pend;
        mif.PARTITA_IN = (el && end_at != 0 && ntal + 1 == end_at) ? end_val : 2'b00;
        if (el) sb.push_back({mif.MANCHE_IN, mif.PARTITA_IN});
        if (force_en) pend = (cur && nplay == spike_at) ? 2'b10 : force_val;
        else pend = rps(mif.PRIMO, mif.SECONDO);
        prev_play = cur;
    endtask

    task automatic start_match(input logic [3:0] n);
        mif.START = 1'b1;
        mif.NMAN = n;
        model_clr();
        tick();
        mif.START = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mif.DONE && n < budget);
        chk("done_seen", 32'(mif.DONE), 32'd1);
    endtask

    initial begin
        int n;
        mif.START = 1'b0; mif.NMAN = 4'h0;
        mif.MANCHE_IN = 2'b00; mif.PARTITA_IN = 2'b00;
        sif.START = 1'b0; sif.NMAN = 4'h0;
        sif.MANCHE_IN = 2'b11; sif.PARTITA_IN = 2'b00;
        force_en = 1'b0; force_val = 2'b11; spike_at = 0;
        end_at = 0; end_val = 2'b00; pend = 2'b00; done_cnt = 0;
        model_clr();

        #1;
        chk("rst_primo", 32'(mif.PRIMO), 32'd0);
        chk("rst_secondo", 32'(mif.SECONDO), 32'd0);
        chk("rst_inizia", 32'(mif.INIZIA), 32'd0);
        chk("rst_busy", 32'(mif.BUSY), 32'd0);
        chk("rst_done", 32'(mif.DONE), 32'd0);
        chk("rst_result", 32'(mif.RESULT), 32'd0);
        chk("rst_tallies", 32'(dut_sum()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        end_at = 5; end_val = 2'b01;
        start_match(4'b1101);
        chk("init_inizia", 32'(mif.INIZIA), 32'd1);
        chk("init_primo", 32'(mif.PRIMO), 32'd3);
        chk("init_secondo", 32'(mif.SECONDO), 32'd1);
        chk("init_busy", 32'(mif.BUSY), 32'd1);
        run_to_done(40);
        chk("basic_result", 32'(mif.RESULT), 32'd1);
        chk("basic_timeout", 32'(mif.TIMEOUT), 32'd0);
        chk("basic_sum", 32'(dut_sum()), 32'd5);
        chk("post_primo", 32'(mif.PRIMO), 32'd0);
        chk("post_secondo", 32'(mif.SECONDO), 32'd0);
        chk("post_busy", 32'(mif.BUSY), 32'd0);
        tick();
        chk("done_one_cycle", 32'(mif.DONE), 32'd0);

        force_en = 1'b1; force_val = 2'b11; spike_at = 3;
        end_at = 6; end_val = 2'b11;
        start_match(4'b0110);
        run_to_done(40);
        chk("lat_wins2", 32'(mif.WINS2), 32'd1);
        chk("lat_draws", 32'(mif.DRAWS), 32'd5);
        chk("lat_result", 32'(mif.RESULT), 32'd3);

        force_en = 1'b0; end_at = 0;
        start_match(4'b0101);
        run_to_done(60);
        chk("tmo_nplay", 32'(nplay), 32'd32);
        chk("tmo_flag", 32'(mif.TIMEOUT), 32'd1);
        chk("tmo_result", 32'(mif.RESULT), 32'd0);
        chk("tmo_sum", 32'(dut_sum()), 32'd31);
        end_at = 4; end_val = 2'b11;
        start_match(4'b1010);
        chk("tmo_cleared", 32'(mif.TIMEOUT), 32'd0);
        run_to_done(40);
        chk("restart_result", 32'(mif.RESULT), 32'd3);

        end_at = 31; end_val = 2'b10;
        start_match(4'b0111);
        repeat (6) tick();
        mif.START = 1'b1; mif.NMAN = 4'b0000;
        tick();
        mif.START = 1'b0;
        run_to_done(60);
        chk("bnd_nplay", 32'(nplay), 32'd32);
        chk("bnd_result", 32'(mif.RESULT), 32'd2);
        chk("bnd_timeout", 32'(mif.TIMEOUT), 32'd0);
        chk("bnd_sum", 32'(dut_sum()), 32'd31);
        tick();
        chk("done_count", 32'(done_cnt), 32'd5);

        end_at = 0;
        start_match(4'b1111);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("rmid_busy", 32'(mif.BUSY), 32'd0);
        chk("rmid_primo", 32'(mif.PRIMO), 32'd0);
        chk("rmid_secondo", 32'(mif.SECONDO), 32'd0);
        chk("rmid_done", 32'(mif.DONE), 32'd0);
        chk("rmid_result", 32'(mif.RESULT), 32'd0);
        chk("rmid_tallies", 32'(dut_sum()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clr();
        pend = 2'b00;
        repeat (3) tick();
        chk("rmid_no_done", 32'(done_cnt), 32'd5);
        chk("rmid_idle", 32'(mif.BUSY), 32'd0);

        sif.START = 1'b1;
        @(negedge clk);
        sif.START = 1'b0;
        n = 0;
        while (!sif.DONE && n < 100) begin
            tick();
            n++;
            if (n == 40) chk("sat_hold", 32'(sif.DRAWS), 32'd31);
        end
        chk("sat_done", 32'(sif.DONE), 32'd1);
        chk("sat_draws", 32'(sif.DRAWS), 32'd31);
        chk("sat_timeout", 32'(sif.TIMEOUT), 32'd1);
        chk("sat_wins1", 32'(sif.WINS1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
